// File: rtl/musa_stage_sequencer.sv
// Multi-cycle control sequencer for the MUSA core: walks IFH/ID/EX/MEM/WB/HLT,
// emits per-stage strobes and counts retired instructions.
module musa_stage_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic [2:0]  stage,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic        halted,
  output logic        illegal_op,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    ST_IFH = 3'b000,
    ST_ID  = 3'b001,
    ST_EX  = 3'b010,
    ST_MEM = 3'b011,
    ST_WB  = 3'b100,
    ST_HLT = 3'b101
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] retired_q, retired_d;

  logic is_r, is_ialu, is_lw, is_sw, is_br, is_nop, is_halt, is_undef;

  always_comb begin
    is_r    = 1'b0;
    is_ialu = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_br   = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      6'b000000:                                    is_r    = 1'b1;
      6'b001000, 6'b001010, 6'b001100, 6'b001101:   is_ialu = 1'b1;
      6'b100011:                                    is_lw   = 1'b1;
      6'b101011:                                    is_sw   = 1'b1;
      6'b000100, 6'b001001, 6'b010001,
      6'b000011, 6'b000111:                         is_br   = 1'b1;
      6'b000001:                                    is_nop  = 1'b1;
      6'b000010:                                    is_halt = 1'b1;
      default: ;
    endcase
    is_undef = ~(is_r | is_ialu | is_lw | is_sw | is_br | is_nop | is_halt);
  end

  // Strobes are gated by rst_n as well as run so nothing leaks out while reset is held.
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_we     = 1'b0;
    pc_we      = 1'b0;
    illegal_op = 1'b0;
    if (run && rst_n) begin
      case (state_q)
        ST_IFH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we   = 1'b1;
            state_d = ST_ID;
          end
        end
        ST_ID: begin
          if (is_halt) begin
            state_d = ST_HLT;
          end else if (is_nop) begin
            pc_we   = 1'b1;
            state_d = ST_IFH;
          end else if (is_undef) begin
            illegal_op = 1'b1;
            pc_we      = 1'b1;
            state_d    = ST_IFH;
          end else begin
            state_d = ST_EX;
          end
        end
        ST_EX: begin
          if (is_br) begin
            pc_we   = 1'b1;
            state_d = ST_IFH;
          end else if (is_lw || is_sw) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_sw;
          if (dmem_ready) begin
            if (is_sw) begin
              pc_we   = 1'b1;
              state_d = ST_IFH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          reg_we  = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_IFH;
        end
        ST_HLT: state_d = ST_HLT;
        default: state_d = ST_IFH;
      endcase
    end
  end

  assign retired_d = retired_q + {15'd0, pc_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IFH;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign stage   = state_q;
  assign halted  = rst_n && (state_q == ST_HLT);
  assign retired = retired_q;

endmodule
